// File: rtl/grid_stream_reader_pkg.sv
// Shared defaults and types for the grid RAM stream reader.
package grid_stream_reader_pkg;

    localparam int unsigned DEF_DATA_WIDTH    = 16;
    localparam int unsigned DEF_ADDRESS_WIDTH = 12;
    localparam int unsigned DEF_GRID_W        = 50;
    localparam int unsigned DEF_GRID_H        = 50;

    // Tag bits carried next to each cell word: row(6) + col(6) + last(1).
    localparam int unsigned TAG_WIDTH = 13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/grid_stream_reader_fifo2.sv
// Two-entry synchronous FIFO absorbing the one-cycle RAM read latency.
module stream_fifo2
    import grid_stream_reader_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_DATA_WIDTH + TAG_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;

    assign dout  = mem[rd_ptr];
    assign empty = (count == 2'd0);
    assign full  = (count == 2'd2);

    // Pointer and occupancy bookkeeping; push while full is fine when a pop frees the head slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage; contents need no reset because the reader masks the head while empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && empty));
    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: rtl/grid_stream_reader.sv
// Raster-order read initiator for the grid RAM, emitting tagged cells as a valid/ready stream.
module grid_stream_reader
    import grid_stream_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int unsigned GRID_W        = DEF_GRID_W,
    parameter int unsigned GRID_H        = DEF_GRID_H
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic                     ram_write_en,
    output logic [DATA_WIDTH-1:0]    ram_data_in,
    input  logic [DATA_WIDTH-1:0]    ram_data_out,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_WIDTH-1:0]    m_data,
    output logic [5:0]               m_row,
    output logic [5:0]               m_col,
    output logic                     m_last
);

    localparam int unsigned FIFO_WIDTH = DATA_WIDTH + TAG_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(GRID_W * GRID_H - 1);
    localparam logic [5:0] LAST_COL = 6'(GRID_W - 1);

    state_t state, state_next;

    logic [ADDRESS_WIDTH-1:0] addr_cnt;
    logic [ADDRESS_WIDTH-1:0] addr_hold;
    logic [5:0]               row_cnt;
    logic [5:0]               col_cnt;
    logic                     inflight;
    logic [5:0]               tag_row;
    logic [5:0]               tag_col;
    logic                     tag_last;
    logic                     done_q;

    logic                     issue;
    logic                     room;
    logic                     pop;
    logic [FIFO_WIDTH-1:0]    fifo_din;
    logic [FIFO_WIDTH-1:0]    fifo_dout;
    logic [1:0]               fifo_count;
    logic                     fifo_empty;
    logic                     fifo_full;

    stream_fifo2 #(
        .WIDTH(FIFO_WIDTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (inflight),
        .pop  (pop),
        .din  (fifo_din),
        .dout (fifo_dout),
        .count(fifo_count),
        .empty(fifo_empty),
        .full (fifo_full)
    );

    assign fifo_din = {ram_data_out, tag_row, tag_col, tag_last};

    assign m_valid = !fifo_empty;
    assign pop     = m_valid & m_ready;
    assign m_data  = m_valid ? fifo_dout[FIFO_WIDTH-1 -: DATA_WIDTH] : '0;
    assign m_row   = m_valid ? fifo_dout[12:7] : '0;
    assign m_col   = m_valid ? fifo_dout[6:1]  : '0;
    assign m_last  = m_valid & fifo_dout[0];

    // count + inflight - pop < 2; a pop implies count >= 1, so that reduces to "not (full and inflight)".
    assign room = pop ? !(fifo_full & inflight)
                      : (({1'b0, fifo_count} + {2'b00, inflight}) < 3'd2);

    assign ram_addr     = (state == IDLE) ? '0 : (issue ? addr_cnt : addr_hold);
    assign ram_write_en = 1'b0;
    assign ram_data_in  = '0;
    assign done         = done_q;
    assign busy         = (state != IDLE) | done_q;

    // State register and end-of-sweep pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            done_q <= (state == DRAIN) && pop && m_last;
        end
    end

    // Next-state and read-issue decision.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                issue = room;
                if (room && (addr_cnt == LAST_ADDR)) state_next = DRAIN;
            end
            DRAIN: begin
                if (pop && m_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Address, row and column counters; cleared while idle so each sweep starts at cell 0.
    always_ff @(posedge clk) begin
        if (rst || (state == IDLE)) begin
            addr_cnt  <= '0;
            addr_hold <= '0;
            row_cnt   <= '0;
            col_cnt   <= '0;
        end else if (issue) begin
            addr_hold <= addr_cnt;
            if (addr_cnt != LAST_ADDR) addr_cnt <= addr_cnt + 1'b1;
            if (col_cnt == LAST_COL) begin
                col_cnt <= '0;
                row_cnt <= row_cnt + 6'd1;
            end else begin
                col_cnt <= col_cnt + 6'd1;
            end
        end
    end

    // Tags follow the read by one cycle so they meet the RAM word at the FIFO input.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
            tag_row  <= '0;
            tag_col  <= '0;
            tag_last <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                tag_row  <= row_cnt;
                tag_col  <= col_cnt;
                tag_last <= (addr_cnt == LAST_ADDR);
            end
        end
    end

endmodule

// File: tb/tb_grid_stream_reader.sv
// Self-checking bench for grid_stream_reader: timing table, scoreboard monitor and corner-case sequences.
module tb_grid_stream_reader;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 12;
    localparam int unsigned GW = 50;
    localparam int unsigned GH = 50;
    localparam int unsigned N  = GW * GH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          m_ready = 1'b0;
    logic          busy, done, ram_write_en, m_valid, m_last;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data_in;
    logic [DW-1:0] ram_data_out = '0;
    logic [DW-1:0] m_data;
    logic [5:0]    m_row, m_col;

    logic [DW-1:0] mem [N];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    grid_stream_reader #(
        .DATA_WIDTH   (DW),
        .ADDRESS_WIDTH(AW),
        .GRID_W       (GW),
        .GRID_H       (GH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .ram_addr    (ram_addr),
        .ram_write_en(ram_write_en),
        .ram_data_in (ram_data_in),
        .ram_data_out(ram_data_out),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_row       (m_row),
        .m_col       (m_col),
        .m_last      (m_last)
    );

    // Grid RAM model with one-cycle registered read.
    always @(posedge clk) begin
        if (ram_addr < AW'(N)) ram_data_out <= mem[ram_addr];
        else                   ram_data_out <= '0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted beat must be the next cell in raster order.
    bit            mon_en     = 1'b0;
    int            exp_idx    = 0;
    int            beats      = 0;
    int            done_cnt   = 0;
    bit            prev_stall = 1'b0;
    logic [28:0]   prev_beat  = '0;

    always @(negedge clk) begin
        if (rst || !mon_en) begin
            prev_stall = 1'b0;
        end else begin
            chk("ram_write_en", ram_write_en, 0);
            if (ram_addr >= AW'(N)) chk("ram_addr_range", ram_addr, N - 1);
            if (prev_stall) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_beat", {m_data, m_row, m_col, m_last}, prev_beat);
            end
            if (m_valid && m_ready) begin
                if (exp_idx < int'(N)) begin
                    chk("beat_data", m_data, mem[exp_idx]);
                    chk("beat_row",  m_row,  exp_idx / int'(GW));
                    chk("beat_col",  m_col,  exp_idx % int'(GW));
                    chk("beat_last", m_last, (exp_idx == int'(N) - 1) ? 1 : 0);
                end else begin
                    chk("extra_beat", exp_idx, N - 1);
                end
                exp_idx++;
                beats++;
            end
            if (done) begin
                chk("beats_before_done", exp_idx, N);
                exp_idx = 0;
                done_cnt++;
            end
            prev_stall = m_valid && !m_ready;
            prev_beat  = {m_data, m_row, m_col, m_last};
        end
    end

    task automatic wait_done(input int budget, input string name);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget && done_cnt == d0; i++) cyc();
        chk(name, done_cnt - d0, 1);
    endtask

    typedef struct {
        int          cyc;
        logic        valid;
        logic [15:0] data;
        logic [5:0]  row;
        logic [5:0]  col;
        logic        last;
        logic        done;
        logic        busy;
        logic [11:0] addr;
    } vec_t;

    function automatic vec_t mk(int c, int v, int d, int r, int k, int l, int dn, int b, int a);
        vec_t t;
        t.cyc   = c;
        t.valid = v[0];
        t.data  = d[15:0];
        t.row   = r[5:0];
        t.col   = k[5:0];
        t.last  = l[0];
        t.done  = dn[0];
        t.busy  = b[0];
        t.addr  = a[11:0];
        return t;
    endfunction

    vec_t tbl [13];

    initial begin
        int b0, d0, k;

        //           cyc  val data row col last done busy addr
        tbl[0]  = mk(0,    0, 0,    0,  0,  0,   0,   0,   0);
        tbl[1]  = mk(1,    0, 0,    0,  0,  0,   0,   1,   0);
        tbl[2]  = mk(2,    0, 0,    0,  0,  0,   0,   1,   1);
        tbl[3]  = mk(3,    1, 0,    0,  0,  0,   0,   1,   2);
        tbl[4]  = mk(4,    1, 1,    0,  1,  0,   0,   1,   3);
        tbl[5]  = mk(52,   1, 49,   0,  49, 0,   0,   1,   51);
        tbl[6]  = mk(53,   1, 50,   1,  0,  0,   0,   1,   52);
        tbl[7]  = mk(1277, 1, 1274, 25, 24, 0,   0,   1,   1276);
        tbl[8]  = mk(2501, 1, 2498, 49, 48, 0,   0,   1,   2499);
        tbl[9]  = mk(2502, 1, 2499, 49, 49, 1,   0,   1,   2499);
        tbl[10] = mk(2503, 0, 0,    0,  0,  0,   1,   1,   0);
        tbl[11] = mk(2504, 0, 0,    0,  0,  0,   0,   0,   0);
        tbl[12] = mk(2505, 0, 0,    0,  0,  0,   0,   0,   0);

        // Reset state
        rst = 1'b1;
        cyc();
        cyc();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_row", m_row, 0);
        chk("rst_col", m_col, 0);
        chk("rst_last", m_last, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_we", ram_write_en, 0);
        chk("rst_wdata", ram_data_in, 0);
        cyc();
        rst = 1'b0;
        cyc();

        // Full-rate sweep against the timing table
        for (int i = 0; i < int'(N); i++) mem[i] = DW'(i);
        mon_en  = 1'b1;
        exp_idx = 0;
        b0      = beats;
        d0      = done_cnt;
        m_ready = 1'b1;
        start   = 1'b1;
        for (int c = 0; c <= 2505; c++) begin
            @(negedge clk);
            for (int e = 0; e < 13; e++) begin
                if (tbl[e].cyc == c) begin
                    chk("tbl_valid", m_valid, tbl[e].valid);
                    chk("tbl_data",  m_data,  tbl[e].data);
                    chk("tbl_row",   m_row,   tbl[e].row);
                    chk("tbl_col",   m_col,   tbl[e].col);
                    chk("tbl_last",  m_last,  tbl[e].last);
                    chk("tbl_done",  done,    tbl[e].done);
                    chk("tbl_busy",  busy,    tbl[e].busy);
                    chk("tbl_addr",  ram_addr, tbl[e].addr);
                end
            end
            cyc();
            start = 1'b0;
        end
        chk("full_beats", beats - b0, N);
        chk("full_dones", done_cnt - d0, 1);

        // Random backpressure with random cell contents
        for (int i = 0; i < int'(N); i++) mem[i] = DW'($urandom);
        b0    = beats;
        start = 1'b1;
        cyc();
        start = 1'b0;
        d0    = done_cnt;
        for (int i = 0; i < 20000 && done_cnt == d0; i++) begin
            m_ready = ($urandom % 2) == 0;
            cyc();
        end
        chk("rand_done", done_cnt - d0, 1);
        chk("rand_beats", beats - b0, N);

        // Long stall after the first beat
        for (int i = 0; i < int'(N); i++) mem[i] = DW'(i);
        m_ready = 1'b0;
        start   = 1'b1;
        cyc();
        start = 1'b0;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_valid) break;
            k++;
            cyc();
        end
        chk("stall_first_valid", m_valid, 1);
        cyc();
        for (int s = 0; s < 20; s++) begin
            @(negedge clk);
            chk("stall_fifo_count", dut.u_fifo.count, 2);
            chk("stall_addr", ram_addr, 1);
            chk("stall_head", m_data, 0);
            cyc();
        end
        m_ready = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            chk("release_valid", m_valid, 1);
            chk("release_data", m_data, j);
            cyc();
        end
        wait_done(3000, "stall_done");

        // start pulsed during RUN is ignored
        b0      = beats;
        d0      = done_cnt;
        m_ready = 1'b1;
        start   = 1'b1;
        cyc();
        start = 1'b0;
        repeat (99) cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        wait_done(3000, "ignore_start_done");
        repeat (10) cyc();
        chk("ignore_start_dones", done_cnt - d0, 1);
        chk("ignore_start_beats", beats - b0, N);
        chk("ignore_start_busy", busy, 0);

        // Reset mid-sweep at cycle 500, then a clean sweep
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (499) cyc();
        rst     = 1'b1;
        exp_idx = 0;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", m_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_addr", ram_addr, 0);
        chk("midrst_done", done, 0);
        cyc();
        @(negedge clk);
        chk("midrst_stale_word", m_valid, 0);
        cyc();
        b0    = beats;
        start = 1'b1;
        cyc();
        start = 1'b0;
        wait_done(3000, "midrst_resweep_done");
        chk("midrst_resweep_beats", beats - b0, N);

        // Back-to-back sweeps with start held high
        b0    = beats;
        d0    = done_cnt;
        start = 1'b1;
        for (int i = 0; i < 3000 && done_cnt == d0; i++) cyc();
        start = 1'b0;
        chk("b2b_first_done", done_cnt - d0, 1);
        @(negedge clk);
        chk("b2b_busy_after_done", busy, 1);
        cyc();
        cyc();
        @(negedge clk);
        chk("b2b_second_valid", m_valid, 1);
        chk("b2b_second_data", m_data, mem[0]);
        wait_done(3000, "b2b_second_done");
        chk("b2b_beats", beats - b0, 2 * N);
        repeat (5) cyc();
        chk("b2b_idle_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
